pixel_writer: RTL and testbench

- Downstream stage of the line rasteriser. Consumes its `plot`/`x`/`y` pixel stream and buffers pixels in a small FIFO.
- Converts each (x,y) to a linear framebuffer address and writes it to the shared SRAM through a request/grant arbiter port. The VGA reader has priority on that arbiter.
- Back-pressures the rasteriser via `ready`, which drives the rasteriser's `clk_en`.

---
 rtl/pixel_writer_if.sv | 28 ++
 rtl/pixel_writer.sv | 163 ++++++++++++++++
 tb/tb_pixel_writer.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_writer_if.sv
// SRAM write port between pixel_writer (master) and the shared framebuffer arbiter (slave).
// mem_req is held until mem_grant; mem_we pulses for one cycle with mem_addr/mem_wdata stable.
interface pixel_writer_if #(
    parameter int ADDR_W  = 19,
    parameter int COLOR_W = 4
);
    logic               mem_req;
    logic               mem_grant;
    logic               mem_we;
    logic [ADDR_W-1:0]  mem_addr;
    logic [COLOR_W-1:0] mem_wdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_grant
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_grant
    );
endinterface

// File: rtl/pixel_writer.sv
// Pixel FIFO + SRAM write sequencer for the rasteriser stream; PIXEL_WRITER_CLIP_EN drops off-screen pixels.
// Latency: accept at edge N -> mem_req after N+1, mem_we after N+2 (grant high), idle after N+3.
// Backpressure: ready low while the FIFO is full; mem_grant may stall indefinitely.
module pw_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [W-1:0]           push_dat,
    input  logic                   pop,
    output logic [W-1:0]           head_dat,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  store [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (push) store[wr_ptr] <= push_dat;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head_dat = store[rd_ptr];
endmodule

module pixel_writer #(
    parameter int WIDTH      = 640,
    parameter int HEIGHT     = 480,
    parameter int ADDR_W     = 19,
    parameter int COLOR_W    = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               plot,
    input  logic [9:0]         x,
    input  logic [9:0]         y,
    input  logic [COLOR_W-1:0] color,
    output logic               ready,
    pixel_writer_if.master     mem,
    output logic               idle,
`ifdef PIXEL_WRITER_CLIP_EN
    output logic               clipped,
`endif
    output logic [19:0]        pixel_count
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [COLOR_W-1:0] color;
    } pix_t;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WRITE} state_t;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || HEIGHT < 1 || WIDTH < 1)
    begin : g_bad_param
        $error("pixel_writer: FIFO_DEPTH must be a power of two >= 2, WIDTH/HEIGHT >= 1");
    end

    state_t           state;
    state_t           next_state;
    logic             pop;
    logic             accept;
    logic             push;
    pix_t             push_pix;
    pix_t             head_pix;
    logic [CNT_W-1:0] fifo_count;

    assign ready  = (fifo_count != CNT_W'(FIFO_DEPTH));
    assign accept = plot && ready;

    // Arithmetic done modulo 2^ADDR_W, which equals truncating the full product.
    assign push_pix.addr  = ADDR_W'(y) * ADDR_W'(WIDTH) + ADDR_W'(x);
    assign push_pix.color = color;

`ifdef PIXEL_WRITER_CLIP_EN
    logic off_screen;
    assign off_screen = (int'(x) >= WIDTH) || (int'(y) >= HEIGHT);
    assign push       = accept && !off_screen;

    always_ff @(posedge clk) begin
        if (reset) clipped <= 1'b0;
        else       clipped <= accept && off_screen;
    end
`else
    assign push = accept;
`endif

    pw_fifo #(
        .W     ($bits(pix_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_dat (push_pix),
        .pop      (pop),
        .head_dat (head_pix),
        .count    (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        pop        = 1'b0;
        case (state)
            S_IDLE: begin
                if (fifo_count != '0) begin
                    pop        = 1'b1;
                    next_state = S_REQ;
                end
            end
            S_REQ:   if (mem.mem_grant) next_state = S_WRITE;
            S_WRITE: next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Address/data are captured on pop and held through REQ and WRITE.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
        end else if (pop) begin
            mem.mem_addr  <= head_pix.addr;
            mem.mem_wdata <= head_pix.color;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)                 pixel_count <= '0;
        else if (state == S_WRITE) pixel_count <= pixel_count + 20'd1;
    end

    assign mem.mem_req = (state == S_REQ);
    assign mem.mem_we  = (state == S_WRITE);
    assign idle        = (state == S_IDLE) && (fifo_count == '0) && !accept;
endmodule

// File: tb/tb_pixel_writer.sv
// Randomised bench for pixel_writer: expected writes come from y*640+x arithmetic per accepted pixel.
module tb_pixel_writer;
    localparam int WIDTH   = 640;
    localparam int HEIGHT  = 480;
    localparam int ADDR_W  = 19;
    localparam int COLOR_W = 4;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               plot = 1'b0;
    logic [9:0]         x = '0;
    logic [9:0]         y = '0;
    logic [COLOR_W-1:0] color = '0;
    logic               ready;
    logic               idle;
    logic [19:0]        pixel_count;
`ifdef PIXEL_WRITER_CLIP_EN
    logic               clipped;
`endif

    pixel_writer_if #(.ADDR_W(ADDR_W), .COLOR_W(COLOR_W)) mem_if ();

    pixel_writer #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .ADDR_W(ADDR_W), .COLOR_W(COLOR_W), .FIFO_DEPTH(8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .plot        (plot),
        .x           (x),
        .y           (y),
        .color       (color),
        .ready       (ready),
        .mem         (mem_if),
        .idle        (idle),
`ifdef PIXEL_WRITER_CLIP_EN
        .clipped     (clipped),
`endif
        .pixel_count (pixel_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int tmo = 0;
    int stable_err = 0;
    int clip_cnt = 0;
    int grant_mode = 0;     // 0 low, 1 high, 2 toggle every cycle
    logic [22:0] obs_q[$];
    logic [22:0] exp_q[$];
    logic        prev_req = 1'b0;
    logic [22:0] prev_bus = '0;

    always @(negedge clk) begin
        case (grant_mode)
            1:       mem_if.mem_grant = 1'b1;
            2:       mem_if.mem_grant = (mem_if.mem_grant === 1'b1) ? 1'b0 : 1'b1;
            default: mem_if.mem_grant = 1'b0;
        endcase
    end

    // Records every write and any change of address/data while a request is pending.
    always @(posedge clk) begin
        if (mem_if.mem_we === 1'b1) obs_q.push_back({mem_if.mem_addr, mem_if.mem_wdata});
        if (!reset && prev_req && (mem_if.mem_req || mem_if.mem_we) &&
            ({mem_if.mem_addr, mem_if.mem_wdata} != prev_bus))
            stable_err++;
        prev_req = (mem_if.mem_req === 1'b1) && !reset;
        prev_bus = {mem_if.mem_addr, mem_if.mem_wdata};
`ifdef PIXEL_WRITER_CLIP_EN
        if (clipped === 1'b1) clip_cnt++;
`endif
    end

    function automatic logic [22:0] exp_entry(input int px, input int py, input int pc);
        int unsigned lin;
        logic [31:0] l32;
        lin = (py * WIDTH + px) % (1 << ADDR_W);
        l32 = lin;
        return {l32[ADDR_W-1:0], 4'(pc)};
    endfunction

    task automatic do_reset();
        plot = 1'b0;
        grant_mode = 0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        obs_q.delete();
        exp_q.delete();
        stable_err = 0;
        clip_cnt = 0;
        tmo = 0;
    endtask

    // Holds plot until the pixel is accepted; records the expected write.
    task automatic send_pixel(input int px, input int py, input int pc, input bit expect_write);
        bit acc;
        acc = 1'b0;
        x = 10'(px); y = 10'(py); color = 4'(pc); plot = 1'b1;
        for (int n = 0; n < 200 && !acc; n++) begin
            acc = ready;
            @(posedge clk); #1;
        end
        plot = 1'b0;
        if (!acc) tmo++;
        else if (expect_write) exp_q.push_back(exp_entry(px, py, pc));
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (idle !== 1'b1 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (idle !== 1'b1) tmo++;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (mem_if.mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req got=%b exp=0", mem_if.mem_req); end
        total++; if (mem_if.mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_we got=%b exp=0", mem_if.mem_we); end
        total++; if (mem_if.mem_addr !== '0) begin bad++; $display("FAIL reset_mem_addr got=%0d exp=0", mem_if.mem_addr); end
        total++; if (mem_if.mem_wdata !== '0) begin bad++; $display("FAIL reset_mem_wdata got=%0d exp=0", mem_if.mem_wdata); end
        total++; if (pixel_count !== 20'd0) begin bad++; $display("FAIL reset_pixel_count got=%0d exp=0", pixel_count); end
        total++; if (idle !== 1'b1) begin bad++; $display("FAIL reset_idle got=%b exp=1", idle); end
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", ready); end
    endtask

    task automatic test_single();
        do_reset();
        grant_mode = 1;
        x = 10'd3; y = 10'd2; color = 4'd5; plot = 1'b1;
        @(posedge clk); #1 plot = 1'b0;
        total++; if (mem_if.mem_req !== 1'b0 || idle !== 1'b0) begin bad++; $display("FAIL single_n0 req=%b idle=%b exp req=0 idle=0", mem_if.mem_req, idle); end
        @(posedge clk); #1;
        total++; if (mem_if.mem_req !== 1'b1 || mem_if.mem_we !== 1'b0) begin bad++; $display("FAIL single_n1 req=%b we=%b exp req=1 we=0", mem_if.mem_req, mem_if.mem_we); end
        total++; if (mem_if.mem_addr !== 19'd1283 || mem_if.mem_wdata !== 4'd5) begin bad++; $display("FAIL single_bus addr=%0d data=%0d exp addr=1283 data=5", mem_if.mem_addr, mem_if.mem_wdata); end
        @(posedge clk); #1;
        total++; if (mem_if.mem_we !== 1'b1 || mem_if.mem_req !== 1'b0) begin bad++; $display("FAIL single_n2 we=%b req=%b exp we=1 req=0", mem_if.mem_we, mem_if.mem_req); end
        @(posedge clk); #1;
        total++; if (mem_if.mem_we !== 1'b0 || idle !== 1'b1 || pixel_count !== 20'd1) begin bad++; $display("FAIL single_n3 we=%b idle=%b count=%0d exp we=0 idle=1 count=1", mem_if.mem_we, idle, pixel_count); end
        total++; if (obs_q.size() != 1) begin bad++; $display("FAIL single_writes got=%0d exp=1", obs_q.size()); end
    endtask

    task automatic test_stall();
        int px[10], py[10], pc[10];
        int idx;
        bit acc;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            px[i] = $urandom_range(0, WIDTH - 1);
            py[i] = $urandom_range(0, HEIGHT - 1);
            pc[i] = $urandom_range(0, 15);
        end
        idx = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (idx < 10) begin
                x = 10'(px[idx]); y = 10'(py[idx]); color = 4'(pc[idx]); plot = 1'b1;
            end
            acc = ready;
            @(posedge clk); #1;
            if (plot && acc) begin
                exp_q.push_back(exp_entry(px[idx], py[idx], pc[idx]));
                idx++;
            end
        end
        total++; if (idx != 9) begin bad++; $display("FAIL stall_accepted got=%0d exp=9", idx); end
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL stall_ready got=%b exp=0", ready); end
        total++; if (mem_if.mem_req !== 1'b1 || {mem_if.mem_addr, mem_if.mem_wdata} !== exp_q[0]) begin bad++; $display("FAIL stall_req req=%b bus=%h exp req=1 bus=%h", mem_if.mem_req, {mem_if.mem_addr, mem_if.mem_wdata}, exp_q[0]); end
        plot = 1'b0;
        grant_mode = 1;
        for (int i = idx; i < 10; i++) send_pixel(px[i], py[i], pc[i], 1'b1);
        wait_idle(200);
        total++; if (obs_q.size() != 10) begin bad++; $display("FAIL stall_writes got=%0d exp=10", obs_q.size()); end
        for (int i = 0; i < 10 && i < obs_q.size(); i++) begin
            total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL stall_order[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]); end
        end
        total++; if (pixel_count !== 20'd10 || stable_err != 0 || tmo != 0) begin bad++; $display("FAIL stall_end count=%0d unstable=%0d timeouts=%0d exp 10/0/0", pixel_count, stable_err, tmo); end
    endtask

    task automatic test_toggle();
        do_reset();
        grant_mode = 2;
        for (int i = 0; i < 16; i++)
            send_pixel($urandom_range(0, WIDTH - 1), $urandom_range(0, HEIGHT - 1), $urandom_range(0, 15), 1'b1);
        wait_idle(300);
        total++; if (obs_q.size() != 16) begin bad++; $display("FAIL toggle_writes got=%0d exp=16", obs_q.size()); end
        for (int i = 0; i < 16 && i < obs_q.size(); i++) begin
            total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL toggle_order[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]); end
        end
        total++; if (pixel_count !== 20'd16 || stable_err != 0 || tmo != 0) begin bad++; $display("FAIL toggle_end count=%0d unstable=%0d timeouts=%0d exp 16/0/0", pixel_count, stable_err, tmo); end
    endtask

    task automatic test_corners();
        logic [22:0] e;
        do_reset();
        grant_mode = 1;
        send_pixel(0, 0, 9, 1'b1);
        send_pixel(639, 479, 6, 1'b1);
        wait_idle(50);
        total++; if (obs_q.size() != 2) begin bad++; $display("FAIL corner_writes got=%0d exp=2", obs_q.size()); end
        else begin
            e = obs_q[0];
            total++; if (e[22:4] !== 19'd0) begin bad++; $display("FAIL corner_origin addr=%0d exp=0", e[22:4]); end
            e = obs_q[1];
            total++; if (e[22:4] !== 19'd307199) begin bad++; $display("FAIL corner_far addr=%0d exp=307199", e[22:4]); end
        end
    endtask

    task automatic test_reset_mid_write();
        int n;
        do_reset();
        for (int i = 0; i < 5; i++)
            send_pixel($urandom_range(0, WIDTH - 1), $urandom_range(0, HEIGHT - 1), $urandom_range(0, 15), 1'b1);
        repeat (2) @(posedge clk);
        #1 grant_mode = 1;
        n = 0;
        while (mem_if.mem_we !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        total++; if (mem_if.mem_we !== 1'b1) begin bad++; $display("FAIL midreset_reach_write we=%b exp=1", mem_if.mem_we); end
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        total++; if (mem_if.mem_we !== 1'b0 || idle !== 1'b1 || ready !== 1'b1) begin bad++; $display("FAIL midreset_state we=%b idle=%b ready=%b exp 0/1/1", mem_if.mem_we, idle, ready); end
        total++; if (pixel_count !== 20'd0) begin bad++; $display("FAIL midreset_count got=%0d exp=0", pixel_count); end
        repeat (20) @(posedge clk);
        #1;
        total++; if (obs_q.size() != 1 || pixel_count !== 20'd0) begin bad++; $display("FAIL midreset_quiet writes=%0d count=%0d exp 1/0", obs_q.size(), pixel_count); end
        total++; if (obs_q.size() > 0 && obs_q[0] !== exp_q[0]) begin bad++; $display("FAIL midreset_first got=%h exp=%h", obs_q[0], exp_q[0]); end
    endtask

    task automatic test_out_of_range();
        logic [22:0] e;
        do_reset();
        grant_mode = 1;
`ifdef PIXEL_WRITER_CLIP_EN
        send_pixel(640, 0, 3, 1'b0);
        send_pixel(5, 480, 4, 1'b0);
        send_pixel(1, 1, 7, 1'b1);
        wait_idle(50);
        total++; if (clip_cnt != 2) begin bad++; $display("FAIL clip_pulses got=%0d exp=2", clip_cnt); end
        total++; if (pixel_count !== 20'd1) begin bad++; $display("FAIL clip_count got=%0d exp=1", pixel_count); end
        total++; if (obs_q.size() != 1) begin bad++; $display("FAIL clip_writes got=%0d exp=1", obs_q.size()); end
        else begin
            e = obs_q[0];
            total++; if (e !== {19'd641, 4'd7}) begin bad++; $display("FAIL clip_addr got=%h exp addr=641 data=7", e); end
        end
`else
        send_pixel(640, 0, 3, 1'b1);
        wait_idle(50);
        total++; if (obs_q.size() != 1) begin bad++; $display("FAIL noclip_writes got=%0d exp=1", obs_q.size()); end
        else begin
            e = obs_q[0];
            total++; if (e !== {19'd640, 4'd3}) begin bad++; $display("FAIL noclip_addr got=%h exp addr=640 data=3", e); end
        end
`endif
        total++; if (tmo != 0) begin bad++; $display("FAIL range_timeout got=%0d exp=0", tmo); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_corners();
        test_stall();
        test_toggle();
        test_reset_mid_write();
        test_out_of_range();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
